// File: rtl/wb_cpu_bus_arbiter.sv
// Two-master Wishbone B3 arbiter: merges the CPU instruction and data masters onto
// one shared master port with per-cycle round-robin grant and a no-response watchdog.
module wb_cpu_bus_arbiter #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDRESS_WIDTH-1:0] iwbm_adr_i,
  input  logic [DATA_WIDTH-1:0]    iwbm_dat_i,
  input  logic [3:0]               iwbm_sel_i,
  input  logic                     iwbm_we_i,
  input  logic                     iwbm_cyc_i,
  input  logic                     iwbm_stb_i,
  input  logic [2:0]               iwbm_cti_i,
  input  logic [1:0]               iwbm_bte_i,
  output logic [DATA_WIDTH-1:0]    iwbm_dat_o,
  output logic                     iwbm_ack_o,
  output logic                     iwbm_err_o,
  output logic                     iwbm_rty_o,
  input  logic [ADDRESS_WIDTH-1:0] dwbm_adr_i,
  input  logic [DATA_WIDTH-1:0]    dwbm_dat_i,
  input  logic [3:0]               dwbm_sel_i,
  input  logic                     dwbm_we_i,
  input  logic                     dwbm_cyc_i,
  input  logic                     dwbm_stb_i,
  input  logic [2:0]               dwbm_cti_i,
  input  logic [1:0]               dwbm_bte_i,
  output logic [DATA_WIDTH-1:0]    dwbm_dat_o,
  output logic                     dwbm_ack_o,
  output logic                     dwbm_err_o,
  output logic                     dwbm_rty_o,
  output logic [ADDRESS_WIDTH-1:0] wbm_adr_o,
  output logic [DATA_WIDTH-1:0]    wbm_dat_o,
  output logic [3:0]               wbm_sel_o,
  output logic                     wbm_we_o,
  output logic                     wbm_cyc_o,
  output logic                     wbm_stb_o,
  output logic [2:0]               wbm_cti_o,
  output logic [1:0]               wbm_bte_o,
  input  logic [DATA_WIDTH-1:0]    wbm_dat_i,
  input  logic                     wbm_ack_i,
  input  logic                     wbm_err_i,
  input  logic                     wbm_rty_i,
  output logic [1:0]               gnt_o,
  output logic                     bus_timeout_o
);

  localparam int             CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;
  localparam logic [1:0] ABORT = 2'd3;

  logic [1:0]    state_reg, state_next;
  // sel_reg: owner of the current grant, or the last owner while idle (1 = data master)
  logic          sel_reg, sel_next;
  logic [CW-1:0] wdog_reg, wdog_next;

  logic granted, cur_cyc, cur_stb, resp, fire;

  assign granted = (state_reg == GNT_I) || (state_reg == GNT_D);
  assign cur_cyc = sel_reg ? dwbm_cyc_i : iwbm_cyc_i;
  assign cur_stb = sel_reg ? dwbm_stb_i : iwbm_stb_i;
  assign resp    = wbm_ack_i | wbm_err_i | wbm_rty_i;
  // A slave response in the final watchdog cycle wins over the abort.
  assign fire    = granted && cur_stb && !resp && (wdog_reg == LIMIT);

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    wdog_next  = wdog_reg;
    case (state_reg)
      IDLE: begin
        wdog_next = '0;
        if (iwbm_cyc_i && dwbm_cyc_i) begin
          sel_next   = !sel_reg;
          state_next = sel_reg ? GNT_I : GNT_D;
        end else if (dwbm_cyc_i) begin
          sel_next   = 1'b1;
          state_next = GNT_D;
        end else if (iwbm_cyc_i) begin
          sel_next   = 1'b0;
          state_next = GNT_I;
        end
      end
      GNT_I, GNT_D: begin
        if (fire) begin
          state_next = ABORT;
          wdog_next  = '0;
        end else if (!cur_cyc) begin
          state_next = IDLE;
        end else if (resp) begin
          wdog_next = '0;
        end else if (cur_stb) begin
          wdog_next = wdog_reg + CW'(1);
        end
      end
      default: begin
        if (!cur_cyc) state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      sel_reg   <= 1'b0;
      wdog_reg  <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      wdog_reg  <= wdog_next;
    end
  end

  assign wbm_adr_o = sel_reg ? dwbm_adr_i : iwbm_adr_i;
  assign wbm_dat_o = sel_reg ? dwbm_dat_i : iwbm_dat_i;
  assign wbm_sel_o = sel_reg ? dwbm_sel_i : iwbm_sel_i;
  assign wbm_we_o  = sel_reg ? dwbm_we_i  : iwbm_we_i;
  assign wbm_cti_o = sel_reg ? dwbm_cti_i : iwbm_cti_i;
  assign wbm_bte_o = sel_reg ? dwbm_bte_i : iwbm_bte_i;
  assign wbm_cyc_o = granted && cur_cyc;
  assign wbm_stb_o = granted && cur_stb;

  assign iwbm_dat_o = wbm_dat_i;
  assign dwbm_dat_o = wbm_dat_i;
  assign iwbm_ack_o = (state_reg == GNT_I) && wbm_ack_i;
  assign iwbm_err_o = (state_reg == GNT_I) && (wbm_err_i || fire);
  assign iwbm_rty_o = (state_reg == GNT_I) && wbm_rty_i;
  assign dwbm_ack_o = (state_reg == GNT_D) && wbm_ack_i;
  assign dwbm_err_o = (state_reg == GNT_D) && (wbm_err_i || fire);
  assign dwbm_rty_o = (state_reg == GNT_D) && wbm_rty_i;

  assign gnt_o         = (state_reg == IDLE) ? 2'b00 : (sel_reg ? 2'b10 : 2'b01);
  assign bus_timeout_o = fire;

endmodule

// File: tb/tb_wb_cpu_bus_arbiter.sv
// Directed bench for wb_cpu_bus_arbiter: grant, round-robin, bursts, watchdog and reset.
module tb_wb_cpu_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] iwbm_adr_i, iwbm_dat_i, dwbm_adr_i, dwbm_dat_i;
  logic [3:0]  iwbm_sel_i, dwbm_sel_i;
  logic        iwbm_we_i, iwbm_cyc_i, iwbm_stb_i, dwbm_we_i, dwbm_cyc_i, dwbm_stb_i;
  logic [2:0]  iwbm_cti_i, dwbm_cti_i;
  logic [1:0]  iwbm_bte_i, dwbm_bte_i;
  logic [31:0] iwbm_dat_o, dwbm_dat_o;
  logic        iwbm_ack_o, iwbm_err_o, iwbm_rty_o, dwbm_ack_o, dwbm_err_o, dwbm_rty_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic [1:0]  gnt_o;
  logic        bus_timeout_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  wb_cpu_bus_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .iwbm_adr_i(iwbm_adr_i), .iwbm_dat_i(iwbm_dat_i), .iwbm_sel_i(iwbm_sel_i),
    .iwbm_we_i(iwbm_we_i), .iwbm_cyc_i(iwbm_cyc_i), .iwbm_stb_i(iwbm_stb_i),
    .iwbm_cti_i(iwbm_cti_i), .iwbm_bte_i(iwbm_bte_i), .iwbm_dat_o(iwbm_dat_o),
    .iwbm_ack_o(iwbm_ack_o), .iwbm_err_o(iwbm_err_o), .iwbm_rty_o(iwbm_rty_o),
    .dwbm_adr_i(dwbm_adr_i), .dwbm_dat_i(dwbm_dat_i), .dwbm_sel_i(dwbm_sel_i),
    .dwbm_we_i(dwbm_we_i), .dwbm_cyc_i(dwbm_cyc_i), .dwbm_stb_i(dwbm_stb_i),
    .dwbm_cti_i(dwbm_cti_i), .dwbm_bte_i(dwbm_bte_i), .dwbm_dat_o(dwbm_dat_o),
    .dwbm_ack_o(dwbm_ack_o), .dwbm_err_o(dwbm_err_o), .dwbm_rty_o(dwbm_rty_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .gnt_o(gnt_o), .bus_timeout_o(bus_timeout_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // Advance one clock and settle just past the edge; combinational checks follow a #1.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    iwbm_adr_i = '0; iwbm_dat_i = '0; iwbm_sel_i = 4'hF; iwbm_we_i = 1'b0;
    iwbm_cyc_i = 1'b0; iwbm_stb_i = 1'b0; iwbm_cti_i = 3'b000; iwbm_bte_i = 2'b00;
    dwbm_adr_i = '0; dwbm_dat_i = '0; dwbm_sel_i = 4'hF; dwbm_we_i = 1'b0;
    dwbm_cyc_i = 1'b0; dwbm_stb_i = 1'b0; dwbm_cti_i = 3'b000; dwbm_bte_i = 2'b00;
    wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    check("rst_cyc", wbm_cyc_o, 0);
    check("rst_stb", wbm_stb_o, 0);
    check("rst_gnt", gnt_o, 0);
    check("rst_resp", {iwbm_ack_o, iwbm_err_o, iwbm_rty_o, dwbm_ack_o, dwbm_err_o, dwbm_rty_o}, 0);
    check("rst_timeout", bus_timeout_o, 0);

    // 1: single instruction read, slave acks on the third strobe cycle
    iwbm_adr_i = 32'h0000_0100; iwbm_cyc_i = 1'b1; iwbm_stb_i = 1'b1;
    #1;
    check("t1_req_cyc", wbm_cyc_o, 0);
    tick();
    check("t1_cyc", wbm_cyc_o, 1);
    check("t1_gnt", gnt_o, 2'b01);
    check("t1_adr", wbm_adr_o, 32'h0000_0100);
    check("t1_ack_early", iwbm_ack_o, 0);
    tick();
    check("t1_ack_wait", iwbm_ack_o, 0);
    tick();
    wbm_ack_i = 1'b1; wbm_dat_i = 32'hDEAD_BEEF;
    #1;
    check("t1_iack", iwbm_ack_o, 1);
    check("t1_idat", iwbm_dat_o, 32'hDEAD_BEEF);
    check("t1_dack", dwbm_ack_o, 0);
    tick();
    wbm_ack_i = 1'b0; iwbm_cyc_i = 1'b0; iwbm_stb_i = 1'b0;
    #1;
    check("t1_ack_once", iwbm_ack_o, 0);
    tick();
    check("t1_gnt_idle", gnt_o, 0);

    // 2: contention after I was last -> D, dead cycle, then I; repeat gives D again
    iwbm_cyc_i = 1'b1; iwbm_stb_i = 1'b1; dwbm_cyc_i = 1'b1; dwbm_stb_i = 1'b1;
    dwbm_adr_i = 32'h0000_0400;
    tick();
    check("t2_gnt_d", gnt_o, 2'b10);
    check("t2_adr_d", wbm_adr_o, 32'h0000_0400);
    wbm_ack_i = 1'b1;
    #1;
    check("t2_dack", dwbm_ack_o, 1);
    check("t2_iack_blocked", iwbm_ack_o, 0);
    tick();
    wbm_ack_i = 1'b0; dwbm_cyc_i = 1'b0; dwbm_stb_i = 1'b0;
    tick();
    check("t2_dead_cycle", gnt_o, 0);
    check("t2_dead_cyc", wbm_cyc_o, 0);
    tick();
    check("t2_gnt_i", gnt_o, 2'b01);
    wbm_ack_i = 1'b1;
    #1;
    check("t2_iack", iwbm_ack_o, 1);
    tick();
    wbm_ack_i = 1'b0; iwbm_cyc_i = 1'b0; iwbm_stb_i = 1'b0;
    tick();
    iwbm_cyc_i = 1'b1; iwbm_stb_i = 1'b1; dwbm_cyc_i = 1'b1; dwbm_stb_i = 1'b1;
    tick();
    check("t2_regnt_d", gnt_o, 2'b10);
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0; dwbm_cyc_i = 1'b0; dwbm_stb_i = 1'b0;
    tick(); tick();
    check("t2_regnt_i", gnt_o, 2'b01);
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0; iwbm_cyc_i = 1'b0; iwbm_stb_i = 1'b0;
    tick();

    // 3: 4-beat I burst, D requests mid-burst and waits
    iwbm_cyc_i = 1'b1; iwbm_stb_i = 1'b1; iwbm_cti_i = 3'b010; iwbm_adr_i = 32'h0000_0200;
    tick();
    dwbm_cyc_i = 1'b1; dwbm_stb_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      iwbm_adr_i = 32'h0000_0200 + 32'(4 * b);
      iwbm_cti_i = (b == 3) ? 3'b111 : 3'b010;
      wbm_ack_i = 1'b1;
      #1;
      check($sformatf("t3_beat%0d_iack", b), iwbm_ack_o, 1);
      check($sformatf("t3_beat%0d_gnt", b), gnt_o, 2'b01);
      check($sformatf("t3_beat%0d_cti", b), wbm_cti_o, (b == 3) ? 3'b111 : 3'b010);
      check($sformatf("t3_beat%0d_dack", b), dwbm_ack_o, 0);
      tick();
    end
    wbm_ack_i = 1'b0; iwbm_cyc_i = 1'b0; iwbm_stb_i = 1'b0; iwbm_cti_i = 3'b000;
    #1;
    check("t3_hold_gnt", gnt_o, 2'b01);
    tick();
    check("t3_idle", gnt_o, 0);
    tick();
    check("t3_gnt_d", gnt_o, 2'b10);
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0; dwbm_cyc_i = 1'b0; dwbm_stb_i = 1'b0;
    tick(); tick();

    // 4: D write, no response -> timeout on the 4th strobe cycle, late ack ignored
    dwbm_cyc_i = 1'b1; dwbm_stb_i = 1'b1; dwbm_we_i = 1'b1;
    tick();
    check("t4_c1_err", dwbm_err_o, 0);
    tick();
    tick();
    check("t4_c3_timeout", bus_timeout_o, 0);
    tick();
    check("t4_c4_err", dwbm_err_o, 1);
    check("t4_c4_timeout", bus_timeout_o, 1);
    check("t4_c4_ierr", iwbm_err_o, 0);
    tick();
    check("t4_abort_cyc", wbm_cyc_o, 0);
    check("t4_abort_gnt", gnt_o, 2'b10);
    check("t4_abort_err", dwbm_err_o, 0);
    check("t4_abort_timeout", bus_timeout_o, 0);
    wbm_ack_i = 1'b1;
    #1;
    check("t4_late_dack", dwbm_ack_o, 0);
    check("t4_late_iack", iwbm_ack_o, 0);
    tick();
    wbm_ack_i = 1'b0; dwbm_cyc_i = 1'b0; dwbm_stb_i = 1'b0; dwbm_we_i = 1'b0;
    #1;
    check("t4_abort_hold", gnt_o, 2'b10);
    tick();
    check("t4_exit_idle", gnt_o, 0);

    // 5: ack on exactly the 4th strobe cycle beats the watchdog
    dwbm_cyc_i = 1'b1; dwbm_stb_i = 1'b1;
    tick(); tick(); tick(); tick();
    wbm_ack_i = 1'b1;
    #1;
    check("t5_dack", dwbm_ack_o, 1);
    check("t5_derr", dwbm_err_o, 0);
    check("t5_timeout", bus_timeout_o, 0);
    tick();
    wbm_ack_i = 1'b0; dwbm_cyc_i = 1'b0; dwbm_stb_i = 1'b0;
    #1;
    check("t5_no_abort", gnt_o, 2'b10);
    tick();
    check("t5_idle", gnt_o, 0);

    // 6: reset mid D transfer, then contention grants D first
    dwbm_cyc_i = 1'b1; dwbm_stb_i = 1'b1;
    tick(); tick();
    check("t6_cyc", wbm_cyc_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    check("t6_rst_cyc", wbm_cyc_o, 0);
    check("t6_rst_gnt", gnt_o, 0);
    check("t6_rst_dack", dwbm_ack_o, 0);
    iwbm_cyc_i = 1'b1; iwbm_stb_i = 1'b1;
    tick();
    check("t6_gnt_d", gnt_o, 2'b10);
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0; dwbm_cyc_i = 1'b0; dwbm_stb_i = 1'b0;
    tick(); tick();
    check("t6_gnt_i", gnt_o, 2'b01);
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0; iwbm_cyc_i = 1'b0; iwbm_stb_i = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_cpu_bus_arbiter.md
Name: wb_cpu_bus_arbiter

Overview:
- Downstream neighbour of the wishbone_cpu wrapper.
- Merges the CPU instruction master (iwbm_*) and data master (dwbm_*) onto one shared Wishbone B3 master port (wbm_*), which feeds the SoC interconnect.
- Grants the shared port per Wishbone cycle, with round-robin priority.
- A watchdog terminates any slave access that is never acknowledged.

Parameters:
ADDRESS_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses
TIMEOUT_CYCLES, 255, stb-without-response cycles before abort; legal range 2..65535; counter width $clog2(TIMEOUT_CYCLES+1)

Ports:
clk_i  in  1  system clock; all logic on rising edge
rst_i  in  1  synchronous reset, active high
iwbm_adr_i, dwbm_adr_i  in  ADDRESS_WIDTH  master address
iwbm_dat_i, dwbm_dat_i  in  DATA_WIDTH  master write data
iwbm_sel_i, dwbm_sel_i  in  4  byte selects
iwbm_we_i, dwbm_we_i  in  1  write enable
iwbm_cyc_i, dwbm_cyc_i  in  1  cycle request
iwbm_stb_i, dwbm_stb_i  in  1  strobe
iwbm_cti_i, dwbm_cti_i  in  3  cycle type
iwbm_bte_i, dwbm_bte_i  in  2  burst type
iwbm_dat_o, dwbm_dat_o  out  DATA_WIDTH  read data; both driven from wbm_dat_i
iwbm_ack_o, dwbm_ack_o  out  1  acknowledge, granted master only
iwbm_err_o, dwbm_err_o  out  1  error, granted master only; also carries timeout abort
iwbm_rty_o, dwbm_rty_o  out  1  retry, granted master only
wbm_adr_o  out  ADDRESS_WIDTH  shared address
wbm_dat_o  out  DATA_WIDTH  shared write data
wbm_sel_o  out  4  shared selects
wbm_we_o, wbm_cyc_o, wbm_stb_o  out  1  shared controls
wbm_cti_o  out  3  shared cycle type
wbm_bte_o  out  2  shared burst type
wbm_dat_i  in  DATA_WIDTH  shared read data
wbm_ack_i, wbm_err_i, wbm_rty_i  in  1  shared responses
gnt_o  out  2  current grant: bit0 = instruction, bit1 = data
bus_timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset: rst_i synchronous, active high; clk_i single clock.
  - State goes to IDLE; watchdog counter clears; last-grant flag is set to I, so data wins the first contention.
  - All outputs are 0: wbm_cyc_o, wbm_stb_o, gnt_o, all ack/err/rty, bus_timeout_o.
  - Reset asserted mid-transfer drops wbm_cyc_o on the next edge with no response to either master.
- State machine states: IDLE, GNT_I, GNT_D, ABORT.
- IDLE:
  - If exactly one cyc_i is high, go to that master's grant state on the next edge.
  - If both are high, grant the master that was not granted last.
  - In IDLE, wbm_cyc_o = wbm_stb_o = 0. The other wbm_* outputs hold the last granted master's values (don't-care).
- GNT_x:
  - All wbm_* outputs are combinationally muxed from master x.
  - wbm_ack_i/err_i/rty_i route combinationally to x; the other master sees 0.
  - Grant is held for the whole cycle, including bursts and back-to-back beats, while x_cyc_i = 1. A competing request never pre-empts it.
  - When x_cyc_i = 0, go to IDLE and update last-grant.
  - One dead cycle between consecutive grants is required.
- Latency: request to wbm_cyc_o is 1 cycle. Response pass-through is 0 cycles.
- Watchdog:
  - Clears on entering a grant state and on any wbm_ack_i/err_i/rty_i.
  - Increments each GNT cycle with wbm_stb_o = 1 and no response. It holds when stb is low.
  - On the cycle the count equals TIMEOUT_CYCLES-1 with still no response:
    - x_err_o = 1 for exactly that cycle;
    - bus_timeout_o = 1 for that cycle;
    - next state is ABORT.
  - A slave response arriving in the same cycle takes priority: it passes through and no timeout is raised.
- ABORT:
  - wbm_cyc_o = wbm_stb_o = 0; responses to both masters are 0; gnt_o keeps x.
  - Exit to IDLE when x_cyc_i = 0.
  - Late slave responses are ignored.
- gnt_o is one-hot in GNT/ABORT and 0 in IDLE.

Test Plan:
1. Reset, then single read from I (adr 0x0000_0100), slave acks 2 cycles after stb → wbm_cyc_o high 1 cycle after iwbm_cyc_i; iwbm_ack_o high once with data 0xDEADBEEF; dwbm_ack_o stays 0; gnt_o = 01 then 00.
2. I and D both raise cyc in the same cycle after reset → D granted first (gnt_o = 10). After D drops cyc: 1 idle cycle, then I granted. Repeat the contention → D then I alternate.
3. I runs a 4-beat incrementing burst (cti 010, last beat 111) while D requests mid-burst → all 4 beats go to I without interruption; D is granted only after iwbm_cyc_i falls.
4. TIMEOUT_CYCLES = 4, D write with no slave response → dwbm_err_o and bus_timeout_o pulse on the 4th stb cycle; wbm_cyc_o low in the next cycle; a late wbm_ack_i during ABORT is not forwarded.
5. TIMEOUT_CYCLES = 4, wbm_ack_i arrives on exactly the 4th cycle → ack is forwarded; no err; no bus_timeout_o.
6. rst_i asserted for 1 cycle during a granted D transfer → next cycle wbm_cyc_o = 0 and gnt_o = 00. A subsequent simultaneous request grants D first.
